// File: rtl/sym_packer.sv
// 5-bit symbol to byte packer: rebuilds the MSB-first bitstream into bytes,
// zero-padding (PAD_BIT) and flagging the final byte of each frame.
module sym_packer #(
   parameter logic PAD_BIT = 1'b0
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       in_valid,
   input  logic [4:0] in_data,
   input  logic       in_last,
   output logic       out_valid,
   output logic [7:0] out_data,
   output logic       out_last,
   output logic       busy,
   output logic       err
);

   localparam int unsigned SYM_W  = 5;
   localparam int unsigned BYTE_W = 8;
   localparam int unsigned ACC_W  = 12;
   localparam int unsigned CNT_W  = 4;

   typedef enum logic {
      S_RUN   = 1'b0,
      S_FLUSH = 1'b1
   } state_t;

   state_t              state_q, state_d;
   logic [ACC_W-1:0]    acc_q, acc_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                out_valid_q, out_valid_d;
   logic [BYTE_W-1:0]   out_data_q, out_data_d;
   logic                out_last_q, out_last_d;
   logic                busy_q, busy_d;
   logic                err_q, err_d;

   logic [ACC_W-1:0]    acc_n;
   logic [CNT_W-1:0]    cnt_n;
   logic [CNT_W-1:0]    rem;

   // Place the n (1..8) lowest held bits at the top of a byte, fill the rest with PAD_BIT.
   function automatic logic [BYTE_W-1:0] left_align(input logic [ACC_W-1:0] bits,
                                                    input logic [CNT_W-1:0] n);
      logic [BYTE_W-1:0] body;
      logic [BYTE_W-1:0] pad;
      body = BYTE_W'(bits << (CNT_W'(BYTE_W) - n));
      pad  = PAD_BIT ? (8'hFF >> n) : 8'h00;
      return body | pad;
   endfunction

   assign acc_n = {acc_q[ACC_W-SYM_W-1:0], in_data};
   assign cnt_n = cnt_q + CNT_W'(SYM_W);
   assign rem   = cnt_n - CNT_W'(BYTE_W);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_RUN;
         acc_q       <= '0;
         cnt_q       <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_last_q  <= 1'b0;
         busy_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_last_q  <= out_last_d;
         busy_q      <= busy_d;
         err_q       <= err_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      acc_d       = acc_q;
      cnt_d       = cnt_q;
      out_valid_d = 1'b0;
      out_data_d  = '0;
      out_last_d  = 1'b0;
      err_d       = err_q;

      case (state_q)
         S_RUN: begin
            if (in_valid) begin
               acc_d = acc_n;
               if (cnt_n >= CNT_W'(BYTE_W)) begin
                  out_valid_d = 1'b1;
                  out_data_d  = BYTE_W'(acc_n >> rem);
                  cnt_d       = rem;
                  if (in_last) begin
                     // A leftover tail needs one extra cycle to go out.
                     if (rem == '0) begin
                        out_last_d = 1'b1;
                     end else begin
                        state_d = S_FLUSH;
                     end
                  end
               end else if (in_last) begin
                  out_valid_d = 1'b1;
                  out_data_d  = left_align(acc_n, cnt_n);
                  out_last_d  = 1'b1;
                  cnt_d       = '0;
               end else begin
                  cnt_d = cnt_n;
               end
            end
         end
         S_FLUSH: begin
            out_valid_d = 1'b1;
            out_data_d  = left_align(acc_q, cnt_q);
            out_last_d  = 1'b1;
            cnt_d       = '0;
            state_d     = S_RUN;
            // Symbol offered while flushing is dropped and flagged.
            if (in_valid) begin
               err_d = 1'b1;
            end
         end
         default: begin
            state_d = S_RUN;
            cnt_d   = '0;
         end
      endcase

      busy_d = (state_d == S_FLUSH);
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_last  = out_last_q;
   assign busy      = busy_q;
   assign err       = err_q;

endmodule

// File: doc/sym_packer.md
Name: sym_packer

Overview:
- Single-clock 5-bit-to-8-bit symbol packer. It is the reassembly end of the byte-to-5-bit-symbol stream that the CDC path delivers (in_data 8-bit on clk_1, out_data 5-bit on clk_2).
- It sits in the clk_2 domain, after the CDC output. It accepts one 5-bit symbol per valid cycle and rebuilds the MSB-first bitstream into bytes.
- On a frame-last marker it zero-pads any partial byte and flags the final byte.

Parameters:
- PAD_BIT, 1'b0, value used to fill the unused LSBs of the final partial byte.

Ports:
- clk       input   1  single clock, rising edge
- rst_n     input   1  asynchronous, active-low reset
- in_valid  input   1  in_data/in_last valid this cycle
- in_data   input   5  symbol, bit 4 is the first bit on the wire
- in_last   input   1  qualifies the last symbol of a frame; only meaningful with in_valid
- out_valid output  1  out_data valid, one-cycle pulse per byte
- out_data  output  8  packed byte, bit 7 is the earliest bit
- out_last  output  1  high with out_valid on the final byte of a frame
- busy      output  1  high in FLUSH; upstream must hold in_valid low
- err       output  1  sticky protocol-error flag

Behaviour:
- Reset: asynchronous on rst_n low. All outputs 0. Accumulator acc[11:0]=0, bit count cnt[3:0]=0, state=RUN. Reset mid-frame discards all held bits; no partial byte is emitted.
- All outputs are registered. Latency is 1 cycle from the accepting edge to out_valid. There is no backpressure: at most one byte is emitted per cycle.
- RUN, in_valid=1:
  - acc' = {acc, in_data} truncated to 12 bits; cnt' = cnt + 5.
  - Invariant: cnt ≤ 7 on entry, so cnt' ≤ 12.
- RUN, in_valid=1, in_last=0:
  - cnt' ≥ 8: out_valid=1, out_data=acc'[cnt'-1 -: 8], cnt = cnt'-8.
  - Otherwise: no output, cnt = cnt'.
- RUN, in_valid=1, in_last=1:
  - cnt' ≥ 8 and cnt'-8 == 0: emit the byte with out_last=1; cnt=0; stay in RUN.
  - cnt' ≥ 8 and remainder r = cnt'-8 in 1..4: emit the byte with out_last=0; cnt=r; go to FLUSH.
  - cnt' < 8: emit the cnt' held bits left-aligned, LSBs filled with PAD_BIT, out_last=1; cnt=0.
- FLUSH (exactly 1 cycle):
  - Emit the remaining cnt bits left-aligned, padded with PAD_BIT, with out_last=1.
  - cnt=0, return to RUN. busy=1 throughout this state.
- in_valid=1 while in FLUSH: the symbol is dropped, err is set, and the flush byte is still emitted.
- in_last=1 with in_valid=0: ignored.
- err is sticky; it clears only on reset.
- Idle cycles (in_valid=0) in RUN hold acc and cnt; out_valid=0.
- Frames may be back-to-back: a new frame's first symbol may arrive in the cycle right after an in_last that emitted out_last directly (no FLUSH).

Test Plan:
- Exact fit: 8 symbols 1F,00,1F,00,1F,00,1F,00 on consecutive cycles, in_last on the 8th -> bytes F8,3E,0F,83,E0; out_last only with E0; busy never high.
- Single-symbol frame: in_data=15, in_last=1 -> next cycle out_data=A8, out_last=1, out_valid one cycle.
- Flush path: 1F, then 1F with in_last -> FF (out_last=0) the cycle after the 2nd symbol, then C0 with out_last=1 on the next cycle; busy=1 in that cycle. With PAD_BIT=1 the final byte is FF.
- Gaps: same 8-symbol frame with random idle cycles between symbols -> identical byte sequence; out_valid only in the cycles following byte-completing symbols.
- Protocol error: in_valid asserted during FLUSH -> symbol dropped, err=1 and remains 1; the flush byte is still emitted correctly.
- Reset mid-frame: 3 symbols, then rst_n low for 1 cycle -> all outputs 0 immediately (asynchronous). A new frame of 08 with in_last then yields 40 with out_last, with no stale bits.
